// File: rtl/read_mem_if.sv
// Capture-buffer read port plus the valid/ready sample stream.
// The master modport belongs to read_mem; slave is the memory/host side.
interface read_mem_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_ready;
  logic                  o_last;

  modport master (
    output rd_en, raddr, o_data, o_valid, o_last,
    input  rdata, o_ready
  );

  modport slave (
    input  rd_en, raddr, o_data, o_valid, o_last,
    output rdata, o_ready
  );
endinterface

// File: rtl/read_mem.sv
// Logic-analyzer readout: walks the circular capture buffer oldest-first and
// streams each sample over valid/ready, flagging the final one with o_last.
module read_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  primed,
  output logic                  busy,
  output logic                  done,
  read_mem_if.master            bus
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_SEND  = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [CNT_W-1:0]      r_remaining;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic                  r_rd_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_start_ok;
  logic                  w_handshake;
  logic [CNT_W-1:0]      w_snap_cnt;

  // A start landing in the done-pulse cycle is dropped, not queued.
  assign w_start_ok  = start & ~r_done;
  assign w_handshake = r_valid & bus.o_ready;
  assign w_snap_cnt  = primed ? DEPTH : {1'b0, waddr};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok && (w_snap_cnt != '0)) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_SEND;
      S_SEND: begin
        if (w_handshake) begin
          w_next_state = (r_remaining == ONE) ? S_IDLE : S_ISSUE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: snapshot on start, capture read data, retire on handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_remaining <= '0;
      r_raddr     <= '0;
      r_rd_en     <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_en <= (w_next_state == S_ISSUE);
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_raddr     <= primed ? waddr : '0;
            r_remaining <= w_snap_cnt;
            if (w_snap_cnt == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_data  <= bus.rdata;
          r_valid <= 1'b1;
          r_last  <= (r_remaining == ONE);
        end
        S_SEND: begin
          if (w_handshake) begin
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_remaining <= r_remaining - ONE;
            if (r_remaining == ONE) begin
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end else begin
              r_raddr <= r_raddr + ADDR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_en   = r_rd_en;
  assign bus.raddr   = r_raddr;
  assign bus.o_data  = r_data;
  assign bus.o_valid = r_valid;
  assign bus.o_last  = r_last;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_read_mem.sv
// Bench for read_mem: transaction-level model (expected sample queue plus a
// fixed 3-cycle fetch latency) checked every cycle, directed cases then random.
module tb_read_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] waddr;
  logic       primed;
  logic       busy;
  logic       done;

  read_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  read_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .waddr  (waddr),
    .primed (primed),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  always @(posedge clk) if (bus.rd_en) bus.rdata <= mem[bus.raddr];

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [3:0] addr;
  } exp_t;

  exp_t       q[$];
  logic [7:0] got[$];
  bit         m_valid, m_busy, m_done, m_rst, chk_en;
  int         m_cd;
  int         done_cnt;
  int         vectors, miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a start accepted while idle enqueues the whole oldest-first
  // sample list; each sample appears 3 edges after its trigger and leaves on handshake.
  always @(posedge clk) begin
    bit idle;
    int n;
    logic [3:0] base;
    if (!reset) begin
      q.delete();
      m_valid = 0; m_busy = 0; m_done = 0; m_cd = 0; m_rst = 1; chk_en = 1;
    end else begin
      idle   = !m_busy && !m_done;
      m_rst  = 0;
      m_done = 0;
      if (m_valid && bus.o_ready) begin
        got.push_back(bus.o_data);
        void'(q.pop_front());
        m_valid = 0;
        if (q.size() == 0) begin
          m_done = 1;
          m_busy = 0;
        end else begin
          m_cd = 2;
        end
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) m_valid = 1;
      end
      if (start && idle) begin
        n    = primed ? 16 : int'(waddr);
        base = primed ? waddr : 4'd0;
        if (n == 0) begin
          m_done = 1;
        end else begin
          for (int i = 0; i < n; i++) begin
            exp_t e;
            e.addr = 4'(int'(base) + i);
            e.data = mem[e.addr];
            e.last = (i == n - 1);
            q.push_back(e);
          end
          m_busy = 1;
          m_cd   = 2;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (done) done_cnt++;
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("o_valid", 32'(bus.o_valid), 32'(m_valid));
      check("rd_en", 32'(bus.rd_en), 32'(m_cd == 2));
      if (m_cd == 2 && q.size() > 0) check("raddr", 32'(bus.raddr), 32'(q[0].addr));
      if (m_valid && q.size() > 0) begin
        check("o_data", 32'(bus.o_data), 32'(q[0].data));
        check("o_last", 32'(bus.o_last), 32'(q[0].last));
      end else begin
        check("o_last_idle", 32'(bus.o_last), 32'(0));
      end
      if (m_rst) begin
        check("rst_raddr", 32'(bus.raddr), 32'(0));
        check("rst_odata", 32'(bus.o_data), 32'(0));
      end
    end
  end

  task automatic do_start(input logic [3:0] wa, input logic pr);
    @(negedge clk);
    start = 1'b1; waddr = wa; primed = pr;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while ((m_busy || m_done || q.size() != 0) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (k >= max_cyc) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", k);
    end
  endtask

  task automatic wait_got(input int base, input int n, input int max_cyc);
    int k = 0;
    while ((got.size() - base) < n && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (k >= max_cyc) begin
      vectors++; miscompares++;
      $display("FAIL got_timeout: %0d samples, required %0d", got.size() - base, n);
    end
  endtask

  initial begin
    int b, d0, k;
    reset = 1'b0; start = 1'b0; waddr = '0; primed = 1'b0;
    bus.o_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 1: unprimed, 5 samples
    b = got.size(); d0 = done_cnt;
    do_start(4'd5, 1'b0);
    wait_idle(200);
    check("s1_count", 32'(got.size() - b), 32'd5);
    check("s1_first", 32'(got[b]), 32'hA0);
    check("s1_last", 32'(got[b + 4]), 32'hA4);
    check("s1_done", 32'(done_cnt - d0), 32'd1);

    // 2: primed, wraps 15->0
    b = got.size();
    do_start(4'd6, 1'b1);
    wait_idle(400);
    check("s2_count", 32'(got.size() - b), 32'd16);
    check("s2_first", 32'(got[b]), 32'hA6);
    check("s2_wrap", 32'(got[b + 10]), 32'hA0);
    check("s2_last", 32'(got[b + 15]), 32'hA5);

    // 3: empty buffer
    b = got.size(); d0 = done_cnt;
    do_start(4'd0, 1'b0);
    wait_idle(50);
    repeat (3) @(negedge clk);
    check("s3_count", 32'(got.size() - b), 32'd0);
    check("s3_done", 32'(done_cnt - d0), 32'd1);

    // 4: backpressure on the 2nd sample
    b = got.size();
    do_start(4'd3, 1'b0);
    wait_got(b, 1, 50);
    bus.o_ready = 1'b0;
    k = 0;
    while (!bus.o_valid && k < 20) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    check("s4_held", 32'(bus.o_data), 32'hA1);
    bus.o_ready = 1'b1;
    wait_idle(100);
    check("s4_count", 32'(got.size() - b), 32'd3);
    check("s4_last", 32'(got[b + 2]), 32'hA2);

    // 5: reset during the 3rd sample, then a full restart
    b = got.size();
    do_start(4'd6, 1'b1);
    wait_got(b, 2, 50);
    k = 0;
    while (!bus.o_valid && k < 20) begin @(negedge clk); k++; end
    reset = 1'b0;
    @(negedge clk);
    check("s5_valid", 32'(bus.o_valid), 32'd0);
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    b = got.size();
    do_start(4'd6, 1'b1);
    wait_idle(400);
    check("s5_count", 32'(got.size() - b), 32'd16);
    check("s5_first", 32'(got[b]), 32'hA6);

    // 6: start while busy and in the done cycle is ignored
    b = got.size(); d0 = done_cnt;
    do_start(4'd4, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; waddr = 4'd9;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 100) begin @(negedge clk); k++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; waddr = 4'd4;
    repeat (6) @(negedge clk);
    check("s6_count", 32'(got.size() - b), 32'd4);
    check("s6_last", 32'(got[b + 3]), 32'hA3);
    check("s6_done", 32'(done_cnt - d0), 32'd1);

    // Random: new memory image, random start/ready/waddr/primed every cycle
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.o_ready = ($urandom_range(0, 9) < 7);
      start       = ($urandom_range(0, 5) == 0);
      waddr       = 4'($urandom);
      primed      = 1'($urandom);
    end
    start = 1'b0;
    bus.o_ready = 1'b1;
    wait_idle(400);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
